kernel_scheduler: RTL and testbench
===================================

Name: kernel_scheduler

Overview:
- Owns the 3x3 convolution kernel selection for the camera filter pipeline.
- Accepts kernel-change requests from the user-control logic through a valid/ready handshake.
- Holds each request until the next frame boundary, then drives the new coefficient set and shift onto the convolution datapath.
- After each switch, asserts a flush window so the downstream frame buffer discards pixels that mix old and new kernels.

Parameters:
- DEFAULT_KERNEL, 0, kernel index active out of reset (0..3).
- FLUSH_CYCLES, 8, number of cycles flush_out stays high after a commit; 0 disables the flush.
- AUTO_FRAMES, 60, frames per kernel in auto-cycle mode (only used with the optional feature); valid range 1..255.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- new_frame_in  input  1  one-cycle pulse at the start of each frame.
- req_valid_in  input  1  a kernel-change request is present.
- req_kernel_in  input  2  requested kernel index.
- req_ready_out  output  1  the scheduler can accept a request this cycle.
- auto_in  input  1  enables auto-cycle mode; ignored without the optional feature.
- coeffs_out  output  72  signed 8-bit coefficients; coefficient at row r, column c sits at bits [8*(3r+c)+7 : 8*(3r+c)].
- shift_out  output  8  signed right-shift amount applied after accumulation.
- active_kernel_out  output  2  index of the kernel currently driven.
- flush_out  output  1  downstream must discard output pixels while high.

Behaviour:
- Kernel table (row-major, r0..r2):
  - Kernel 0, identity: centre = 1, all others 0; shift 0.
  - Kernel 1, Gaussian: 1 2 1 / 2 4 2 / 1 2 1; shift 4.
  - Kernel 2, Sobel-X: 1 0 -1 / 2 0 -2 / 1 0 -1; shift 0.
  - Kernel 3, Sobel-Y: -1 -2 -1 / 0 0 0 / 1 2 1; shift 0.
- Reset values (asynchronous):
  - Outputs: coeffs_out = 0, shift_out = 0, active_kernel_out = DEFAULT_KERNEL, flush_out = 0, req_ready_out = 0.
  - Internal: state = RUN, pending and frame counter cleared.
- coeffs_out and shift_out are registered from the table entry of the active kernel, one cycle behind active_kernel_out. The first clock after reset release loads the DEFAULT_KERNEL entry.
- req_ready_out is combinational and equals (state == RUN) and not in reset. A transfer occurs when req_valid_in and req_ready_out are both high.
- States:
  - RUN: ready = 1.
    - A transfer whose index equals the active kernel is accepted and ignored; no flush.
    - A transfer with a different index latches it as pending and moves to PEND.
    - If new_frame_in is high in the same cycle as a different-index transfer, commit immediately: go straight to FLUSH, or stay in RUN when FLUSH_CYCLES = 0.
  - PEND: ready = 0. Requests are held off, not dropped. On new_frame_in, the active kernel takes the pending index and the state moves to FLUSH, or to RUN when FLUSH_CYCLES = 0.
  - FLUSH: ready = 0. flush_out = 1 for exactly FLUSH_CYCLES cycles, starting the cycle after the commit and coinciding with the new coefficients appearing. Then back to RUN. new_frame_in during FLUSH has no effect.
- A commit updates active_kernel_out on the clock edge at which new_frame_in is sampled; coeffs_out updates one edge later.
- Reset asserted mid-PEND or mid-FLUSH discards the pending request and drops flush_out immediately.

Optional Feature:
- KERNEL_SCHED_AUTOCYCLE_EN defined:
  - While auto_in = 1 and state = RUN, an 8-bit counter counts new_frame_in pulses.
  - On the pulse that brings the count to AUTO_FRAMES, the scheduler commits (active + 1) mod 4, wrapping 3 to 0, enters FLUSH and clears the counter.
  - A user transfer in RUN has priority: it clears the counter and follows the normal path.
  - auto_in = 0 or reset clears the counter.
- Undefined: auto_in is unused, no counter is built, and behaviour is request-driven only.

Test Plan:
- Reset with DEFAULT_KERNEL = 0 -> active_kernel_out = 0; coeffs_out = 0 during reset; one cycle after release, coeffs_out centre byte (bits 39:32) = 1 and all other bytes 0; req_ready_out = 1.
- Request kernel 1 mid-frame, new_frame_in 20 cycles later -> ready low for 20+8 cycles; active = 1 at the new_frame_in edge; coeffs_out = Gaussian one cycle later; flush_out high exactly 8 cycles.
- Request kernel 2 with new_frame_in in the same cycle -> immediate commit; no PEND cycle; flush of 8 cycles.
- Request the active kernel -> accepted with ready staying high; no flush; outputs unchanged.
- Assert rst_in during FLUSH -> flush_out drops asynchronously; after release, active = DEFAULT_KERNEL.
- With KERNEL_SCHED_AUTOCYCLE_EN, AUTO_FRAMES = 2, auto_in = 1, starting from kernel 3 -> after 2 frames active = 0 (wrap), then 1 after 2 more; a user request in between resets the count.

Source files
------------

// File: rtl/kernel_scheduler.sv
// -----------------------------------------------------------------------------
// kernel_scheduler
//
// Purpose:
//   Owns the 3x3 convolution kernel selection for the camera filter pipeline.
//   Kernel-change requests arrive on a valid/ready handshake, are held until
//   the next frame boundary, and are then committed.  The new coefficient set
//   and shift are driven onto the convolution datapath.  A flush window
//   follows each switch so that the downstream frame buffer drops pixels
//   computed with a mix of the old and new kernels.
//
// Parameters:
//   DEFAULT_KERNEL  kernel index active out of reset (0..3)
//   FLUSH_CYCLES    cycles flush_out stays high after a commit (0 = no flush)
//   AUTO_FRAMES     frames per kernel in auto-cycle mode (1..255)
//
// Ports:
//   clk_in             in   1   system clock
//   rst_in             in   1   asynchronous, active-high reset
//   new_frame_in       in   1   one-cycle pulse at the start of each frame
//   req_valid_in       in   1   kernel-change request present
//   req_kernel_in      in   2   requested kernel index
//   req_ready_out      out  1   request can be accepted this cycle
//   auto_in            in   1   auto-cycle enable (needs the optional feature)
//   coeffs_out         out  72  signed 8-bit coefficients; row r, column c at
//                               bits [8*(3r+c)+7 : 8*(3r+c)]
//   shift_out          out  8   signed right shift applied after accumulation
//   active_kernel_out  out  2   kernel currently driven
//   flush_out          out  1   downstream discards output pixels while high
//
// Optional feature (compile-time macro KERNEL_SCHED_AUTOCYCLE_EN):
//   When defined, auto_in = 1 makes the scheduler step to the next kernel
//   (wrapping 3 -> 0) every AUTO_FRAMES frames while no user request is
//   being handled.  When undefined, auto_in is ignored and no frame counter
//   is built.
// -----------------------------------------------------------------------------
module kernel_scheduler #(
    parameter int unsigned DEFAULT_KERNEL = 0,
    parameter int unsigned FLUSH_CYCLES   = 8,
    parameter int unsigned AUTO_FRAMES    = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        req_valid_in,
    input  logic [1:0]  req_kernel_in,
    output logic        req_ready_out,
    input  logic        auto_in,
    output logic [71:0] coeffs_out,
    output logic [7:0]  shift_out,
    output logic [1:0]  active_kernel_out,
    output logic        flush_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The flush counter is loaded with FLUSH_CYCLES-1 and the FLUSH state
    // exits when it reaches zero, so it needs to hold values up to
    // FLUSH_CYCLES-1 only.
    localparam int unsigned     CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic             HAS_FLUSH  = (FLUSH_CYCLES != 0);
    localparam logic [1:0]       DEFAULT_IDX = 2'(DEFAULT_KERNEL);

    // -------------------------------------------------------------------------
    // Kernel table.  Bytes are listed most-significant first, i.e. from
    // (r2,c2) down to (r0,c0).
    // -------------------------------------------------------------------------
    function automatic logic [71:0] kernel_coeffs(input logic [1:0] idx);
        logic [71:0] v;
        case (idx)
            // identity: centre = 1
            2'd0: v = {8'h00, 8'h00, 8'h00,  8'h00, 8'h01, 8'h00,  8'h00, 8'h00, 8'h00};
            // Gaussian: 1 2 1 / 2 4 2 / 1 2 1
            2'd1: v = {8'h01, 8'h02, 8'h01,  8'h02, 8'h04, 8'h02,  8'h01, 8'h02, 8'h01};
            // Sobel-X: 1 0 -1 / 2 0 -2 / 1 0 -1
            2'd2: v = {8'hFF, 8'h00, 8'h01,  8'hFE, 8'h00, 8'h02,  8'hFF, 8'h00, 8'h01};
            // Sobel-Y: -1 -2 -1 / 0 0 0 / 1 2 1
            default: v = {8'h01, 8'h02, 8'h01,  8'h00, 8'h00, 8'h00,  8'hFF, 8'hFE, 8'hFF};
        endcase
        return v;
    endfunction

    function automatic logic [7:0] kernel_shift(input logic [1:0] idx);
        return (idx == 2'd1) ? 8'sd4 : 8'sd0;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and combinational next-state signals
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [1:0]         r_active;
    logic [1:0]         r_pending;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_flush;
    logic [71:0]        r_coeffs;
    logic [7:0]         r_shift;

    state_t             w_next_state;
    logic [1:0]         w_next_active;
    logic [1:0]         w_next_pending;
    logic               w_commit;
    logic               w_xfer;
    logic               w_auto_commit;

    assign req_ready_out = (r_state == ST_RUN) && !rst_in;
    assign w_xfer        = req_valid_in && req_ready_out;

    // -------------------------------------------------------------------------
    // Optional auto-cycle frame counter
    // -------------------------------------------------------------------------
`ifdef KERNEL_SCHED_AUTOCYCLE_EN
    logic [7:0] r_frame_cnt;

    // A user transfer takes priority, so the auto step only fires on a frame
    // pulse in which no transfer happens.
    assign w_auto_commit = auto_in && (r_state == ST_RUN) && new_frame_in && !w_xfer &&
                           (r_frame_cnt == 8'(AUTO_FRAMES - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame_cnt <= 8'd0;
        end else if (!auto_in || w_xfer || w_auto_commit) begin
            r_frame_cnt <= 8'd0;
        end else if ((r_state == ST_RUN) && new_frame_in) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end
`else
    logic w_unused_auto;

    assign w_unused_auto = auto_in;
    assign w_auto_commit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        w_next_state   = r_state;
        w_next_active  = r_active;
        w_next_pending = r_pending;
        w_commit       = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_xfer && (req_kernel_in != r_active)) begin
                    if (new_frame_in) begin
                        // Request lands on a frame boundary: no waiting.
                        w_next_active = req_kernel_in;
                        w_commit      = 1'b1;
                    end else begin
                        w_next_pending = req_kernel_in;
                        w_next_state   = ST_PEND;
                    end
                end else if (w_auto_commit) begin
                    w_next_active = r_active + 2'd1;
                    w_commit      = 1'b1;
                end
            end

            ST_PEND: begin
                if (new_frame_in) begin
                    w_next_active = r_pending;
                    w_commit      = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_next_state = ST_RUN;
                end
            end

            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        if (w_commit) begin
            w_next_state = HAS_FLUSH ? ST_FLUSH : ST_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_RUN;
            r_active  <= DEFAULT_IDX;
            r_pending <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            r_state   <= w_next_state;
            r_active  <= w_next_active;
            r_pending <= w_next_pending;
        end
    end

    // The FLUSH state lasts FLUSH_CYCLES cycles; the counter is reloaded on
    // every commit and counts down while in FLUSH.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_flush_cnt <= '0;
        end else if (w_commit && HAS_FLUSH) begin
            r_flush_cnt <= FLUSH_LOAD;
        end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // flush_out trails the FLUSH state by one cycle so that it lines up with
    // the coefficient register, which itself trails the active index.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= (r_state == ST_FLUSH);
        end
    end

    // NOTE: the kernel table is constant logic rather than storage, so only
    // the output register holding the selected entry needs a reset value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_coeffs <= 72'd0;
            r_shift  <= 8'd0;
        end else begin
            r_coeffs <= kernel_coeffs(r_active);
            r_shift  <= kernel_shift(r_active);
        end
    end

    assign coeffs_out        = r_coeffs;
    assign shift_out         = r_shift;
    assign active_kernel_out = r_active;
    assign flush_out         = r_flush;

endmodule

// File: tb/tb_kernel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_kernel_scheduler
//
// Directed steps followed by a randomized phase.  Expected outputs come from
// a cycle model kept here that tracks the active kernel, an optional pending
// request, the number of flush cycles still to run and the auto frame count.
// -----------------------------------------------------------------------------
module tb_kernel_scheduler;

    localparam int DEF_K   = 0;
    localparam int FLUSH_N = 8;
    localparam int AUTO_N  = 2;
`ifdef KERNEL_SCHED_AUTOCYCLE_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        new_frame_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic [1:0]  req_kernel_in = 2'd0;
    logic        req_ready_out;
    logic        auto_in = 1'b0;
    logic [71:0] coeffs_out;
    logic [7:0]  shift_out;
    logic [1:0]  active_kernel_out;
    logic        flush_out;

    always #5 clk_in = ~clk_in;

    kernel_scheduler #(
        .DEFAULT_KERNEL (DEF_K),
        .FLUSH_CYCLES   (FLUSH_N),
        .AUTO_FRAMES    (AUTO_N)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .req_valid_in      (req_valid_in),
        .req_kernel_in     (req_kernel_in),
        .req_ready_out     (req_ready_out),
        .auto_in           (auto_in),
        .coeffs_out        (coeffs_out),
        .shift_out         (shift_out),
        .active_kernel_out (active_kernel_out),
        .flush_out         (flush_out)
    );

    // Row-major coefficient table, index 3r+c.
    int k_tab [4][9] = '{
        '{ 0,  0,  0,  0, 1,  0, 0, 0,  0},
        '{ 1,  2,  1,  2, 4,  2, 1, 2,  1},
        '{ 1,  0, -1,  2, 0, -2, 1, 0, -1},
        '{-1, -2, -1,  0, 0,  0, 1, 2,  1}
    };
    int k_shift [4] = '{0, 4, 0, 0};

    int checks = 0;
    int errors = 0;
    int low_run = 0;
    int flush_run = 0;

    // Reference model state
    int          m_active;
    bit          m_pend_valid;
    int          m_pend;
    int          m_flush_left;
    int          m_auto_cnt;
    logic        m_flush_q;
    logic [71:0] m_coeffs;
    logic [7:0]  m_shift;

    function automatic logic [71:0] pack_kernel(input int k);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'(k_tab[k][i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active     = DEF_K;
        m_pend_valid = 1'b0;
        m_pend       = 0;
        m_flush_left = 0;
        m_auto_cnt   = 0;
        m_flush_q    = 1'b0;
        m_coeffs     = '0;
        m_shift      = '0;
    endtask

    task automatic model_commit(input int k);
        m_active     = k;
        m_flush_left = FLUSH_N;
    endtask

    // Applies the inputs sampled at this rising edge.
    task automatic model_edge();
        m_flush_q = (m_flush_left > 0);
        m_coeffs  = pack_kernel(m_active);
        m_shift   = 8'(k_shift[m_active]);
        if (m_pend_valid) begin
            if (new_frame_in) begin
                m_pend_valid = 1'b0;
                model_commit(m_pend);
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (req_valid_in) begin
            m_auto_cnt = 0;
            if (int'(req_kernel_in) != m_active) begin
                if (new_frame_in) model_commit(int'(req_kernel_in));
                else begin
                    m_pend_valid = 1'b1;
                    m_pend       = int'(req_kernel_in);
                end
            end
        end else if (AUTO_ON && auto_in && new_frame_in) begin
            m_auto_cnt++;
            if (m_auto_cnt == AUTO_N) begin
                m_auto_cnt = 0;
                model_commit((m_active + 1) % 4);
            end
        end
        if (!auto_in) m_auto_cnt = 0;
    endtask

    task automatic check_outputs(input string where);
        logic exp_ready;
        exp_ready = !rst_in && !m_pend_valid && (m_flush_left == 0);
        check({where, ".ready"},  72'(req_ready_out),     72'(exp_ready));
        check({where, ".active"}, 72'(active_kernel_out), 72'(m_active));
        check({where, ".flush"},  72'(flush_out),         72'(m_flush_q));
        check({where, ".coeffs"}, coeffs_out,             m_coeffs);
        check({where, ".shift"},  72'(shift_out),         72'(m_shift));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        if (!req_ready_out) low_run++;
        if (flush_out) flush_run++;
        check_outputs("cyc");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!req_ready_out || flush_out) && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", 72'(n < 100), 72'(1));
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        repeat (3) tick();
    endtask

    logic [71:0] other_mask;

    initial begin
        // ---- Reset state --------------------------------------------------
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.coeffs_zero", coeffs_out, 72'd0);
        rst_in = 1'b0;
        tick();
        other_mask = ~(72'hFF << 32);
        check("first.centre", 72'(coeffs_out[39:32]), 72'd1);
        check("first.others", coeffs_out & other_mask, 72'd0);
        check("first.ready",  72'(req_ready_out), 72'd1);

        // ---- Request kernel 1 mid-frame, frame pulse 20 cycles later ------
        repeat (3) tick();
        low_run = 0; flush_run = 0;
        req_valid_in = 1'b1; req_kernel_in = 2'd1;
        tick();
        req_valid_in = 1'b0;
        repeat (19) tick();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        check("pend.active_at_frame", 72'(active_kernel_out), 72'd1);
        check("pend.coeffs_still_old", coeffs_out, pack_kernel(0));
        tick();
        check("pend.gauss_coeffs", coeffs_out, pack_kernel(1));
        check("pend.gauss_shift", 72'(shift_out), 72'd4);
        check("pend.flush_on", 72'(flush_out), 72'd1);
        wait_idle();
        check("pend.ready_low_cycles", 72'(low_run), 72'd28);
        check("pend.flush_cycles", 72'(flush_run), 72'd8);

        // ---- Request kernel 2 on a frame pulse: immediate commit ----------
        low_run = 0; flush_run = 0;
        req_valid_in = 1'b1; req_kernel_in = 2'd2; new_frame_in = 1'b1;
        tick();
        req_valid_in = 1'b0; new_frame_in = 1'b0;
        check("imm.active", 72'(active_kernel_out), 72'd2);
        wait_idle();
        check("imm.ready_low_cycles", 72'(low_run), 72'd8);
        check("imm.flush_cycles", 72'(flush_run), 72'd8);

        // ---- Request the already active kernel ----------------------------
        low_run = 0; flush_run = 0;
        req_valid_in = 1'b1; req_kernel_in = 2'd2;
        tick();
        req_valid_in = 1'b0;
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        repeat (4) tick();
        check("same.ready_low_cycles", 72'(low_run), 72'd0);
        check("same.flush_cycles", 72'(flush_run), 72'd0);
        check("same.coeffs", coeffs_out, pack_kernel(2));

        // ---- Reset during FLUSH -------------------------------------------
        req_valid_in = 1'b1; req_kernel_in = 2'd3; new_frame_in = 1'b1;
        tick();
        req_valid_in = 1'b0; new_frame_in = 1'b0;
        repeat (2) tick();
        check("rstflush.flush_before", 72'(flush_out), 72'd1);
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        check("rstflush.flush_async", 72'(flush_out), 72'd0);
        check_outputs("rstflush");
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        check("rstflush.active_default", 72'(active_kernel_out), 72'(DEF_K));
        check("rstflush.coeffs_default", coeffs_out, pack_kernel(DEF_K));

`ifdef KERNEL_SCHED_AUTOCYCLE_EN
        // ---- Auto-cycle from kernel 3 with wrap ---------------------------
        req_valid_in = 1'b1; req_kernel_in = 2'd3; new_frame_in = 1'b1;
        tick();
        req_valid_in = 1'b0; new_frame_in = 1'b0;
        wait_idle();
        auto_in = 1'b1;
        frame();
        check("auto.one_frame", 72'(active_kernel_out), 72'd3);
        frame();
        check("auto.wrap", 72'(active_kernel_out), 72'd0);
        wait_idle();
        frame();
        frame();
        check("auto.step", 72'(active_kernel_out), 72'd1);
        wait_idle();
        frame();
        req_valid_in = 1'b1; req_kernel_in = 2'd1;
        tick();
        req_valid_in = 1'b0;
        frame();
        check("auto.count_cleared", 72'(active_kernel_out), 72'd1);
        frame();
        check("auto.after_clear", 72'(active_kernel_out), 72'd2);
        wait_idle();
        auto_in = 1'b0;
`endif

        // ---- Randomized traffic -------------------------------------------
        for (int i = 0; i < 600; i++) begin
            req_valid_in  = ($urandom_range(0, 3) == 0);
            req_kernel_in = 2'($urandom_range(0, 3));
            new_frame_in  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) auto_in = ~auto_in;
            tick();
        end
        req_valid_in = 1'b0;
        new_frame_in = 1'b0;
        auto_in      = 1'b0;
        repeat (30) begin
            new_frame_in = ~new_frame_in;
            tick();
        end
        new_frame_in = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
